// File: rtl/rsa_mont_exit.sv
// Montgomery-domain exit: o_m = a * 2^(-WIDTH) mod N, computed one bit per cycle
// by halving t, with N added first whenever t is odd.
module rsa_mont_exit #(
   parameter int WIDTH = 256
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [WIDTH-1:0] i_N,
   input  logic [WIDTH-1:0] i_a,
   input  logic             i_input_ready,
   output logic [WIDTH-1:0] o_m,
   output logic             o_output_ready,
   output logic             o_busy
);

   localparam int            CW   = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_PROC = 1'b1
   } state_t;

   state_t           state_q;
   logic [WIDTH:0]   t_q;
   logic [WIDTH-1:0] n_q;
   logic [CW-1:0]    count_q;
   logic [WIDTH-1:0] m_q;
   logic             ready_q;
   logic             busy_q;

   logic [WIDTH:0]   n_ext_s;
   logic [WIDTH:0]   sum_s;
   logic [WIDTH:0]   step_d;
   logic [WIDTH:0]   sub_s;
   logic [WIDTH-1:0] m_d;

   // t stays below 2^WIDTH on every step, so t + N never needs more than WIDTH+1 bits
   assign n_ext_s = {1'b0, n_q};
   assign sum_s   = t_q + n_ext_s;
   assign step_d  = t_q[0] ? (sum_s >> 1) : (t_q >> 1);
   assign sub_s   = t_q - n_ext_s;
   assign m_d     = (t_q >= n_ext_s) ? sub_s[WIDTH-1:0] : t_q[WIDTH-1:0];

   // Control FSM with operand capture, iteration counter and registered outputs
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q <= S_IDLE;
         t_q     <= '0;
         n_q     <= '0;
         count_q <= '0;
         m_q     <= '0;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         ready_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (i_input_ready) begin
                  t_q     <= {1'b0, i_a};
                  n_q     <= i_N;
                  count_q <= '0;
                  busy_q  <= 1'b1;
                  state_q <= S_PROC;
               end else begin
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end
            end
            S_PROC: begin
               if (count_q == LAST) begin
                  m_q     <= m_d;
                  ready_q <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end else begin
                  t_q     <= step_d;
                  count_q <= count_q + CW'(1);
                  busy_q  <= 1'b1;
                  state_q <= S_PROC;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign o_m            = m_q;
   assign o_output_ready = ready_q;
   assign o_busy         = busy_q;

endmodule

// File: tb/tb_rsa_mont_exit.sv
// Directed bench for rsa_mont_exit: an 8-bit instance with hand-computed vectors and a
// 256-bit instance checked by mapping results back into the domain with an independent prep model.
module tb_rsa_mont_exit;

   logic         clk;
   logic         rst;
   logic [7:0]   n8, a8, m8;
   logic         st8, rdy8, busy8;
   logic [255:0] n256, a256, m256;
   logic         st256, rdy256, busy256;

   int n_cmp = 0;
   int n_err = 0;
   int cov_sub = 0;

   // With N=13 and WIDTH=8, a=247 ends with t=13=N, forcing the final subtract.
   logic [7:0] va [5] = '{8'd1, 8'd9, 8'd12, 8'd0, 8'd247};
   logic [7:0] ve [5] = '{8'd3, 8'd1, 8'd10, 8'd0, 8'd0};

   rsa_mont_exit #(.WIDTH(8)) u8 (
      .i_clk(clk), .i_rst(rst), .i_N(n8), .i_a(a8), .i_input_ready(st8),
      .o_m(m8), .o_output_ready(rdy8), .o_busy(busy8)
   );

   rsa_mont_exit #(.WIDTH(256)) u256 (
      .i_clk(clk), .i_rst(rst), .i_N(n256), .i_a(a256), .i_input_ready(st256),
      .o_m(m256), .o_output_ready(rdy256), .o_busy(busy256)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Coverage bin: final cycle of the 8-bit instance taking the t >= N subtract path
   always @(negedge clk) begin
      if (u8.busy_q && u8.count_q == 4'd8 && u8.t_q >= {1'b0, u8.n_q}) cov_sub <= cov_sub + 1;
   end

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Maps x into the Montgomery domain: x * 2^256 mod n by 256 modular doublings
   function automatic logic [255:0] to_mont(input logic [255:0] x, input logic [255:0] n);
      logic [256:0] r;
      r = {1'b0, x};
      for (int i = 0; i < 256; i++) begin
         r = r << 1;
         if (r >= {1'b0, n}) r = r - {1'b0, n};
      end
      return r[255:0];
   endfunction

   function automatic logic [255:0] rand256();
      logic [255:0] v;
      for (int k = 0; k < 8; k++) v[32*k +: 32] = $urandom;
      return v;
   endfunction

   task automatic run8(input logic [7:0] n, input logic [7:0] a, output logic [7:0] m, output int lat);
      @(posedge clk); #1;
      n8 = n; a8 = a; st8 = 1'b1;
      @(posedge clk); #1;
      st8 = 1'b0;
      lat = -1; m = 8'd0;
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk); #1;
         if (rdy8) begin lat = c; m = m8; break; end
      end
   endtask

   task automatic run256(input logic [255:0] n, input logic [255:0] a, output logic [255:0] m, output int lat);
      @(posedge clk); #1;
      n256 = n; a256 = a; st256 = 1'b1;
      @(posedge clk); #1;
      st256 = 1'b0;
      lat = -1; m = '0;
      for (int c = 1; c <= 300; c++) begin
         @(posedge clk); #1;
         if (rdy256) begin lat = c; m = m256; break; end
      end
   endtask

   initial begin
      logic [7:0]   m;
      logic [255:0] mw, nw, xw, aw;
      int           lat, pulses, p1, p2;
      logic [7:0]   r1, r2, mid_m;
      logic         mid_rdy, mid_busy;

      rst = 1'b0; st8 = 1'b0; st256 = 1'b0;
      n8 = 8'd13; a8 = 8'd0; n256 = '0; a256 = '0;
      #2;
      check("rst_m8", 256'(m8), 256'd0);
      check("rst_rdy8", 256'(rdy8), 256'd0);
      check("rst_busy8", 256'(busy8), 256'd0);
      check("rst_m256", m256, 256'd0);
      #20 rst = 1'b1;

      for (int i = 0; i < 5; i++) begin
         run8(8'd13, va[i], m, lat);
         check("m8", 256'(m), 256'(ve[i]));
         check("lat8", 256'(lat), 256'd9);
         @(posedge clk); #1;
         check("pulse_width8", 256'(rdy8), 256'd0);
      end
      check("cov_final_subtract", 256'(cov_sub > 0), 256'd1);

      // Busy protection, then a back-to-back start on the done cycle
      @(posedge clk); #1;
      n8 = 8'd13; a8 = 8'd1; st8 = 1'b1;
      @(posedge clk); #1;
      st8 = 1'b0;
      pulses = 0; p1 = -1; p2 = -1; r1 = 8'd0; r2 = 8'd0;
      mid_m = 8'd0; mid_rdy = 1'b1; mid_busy = 1'b0;
      for (int c = 1; c <= 30; c++) begin
         @(posedge clk); #1;
         if (rdy8) begin
            pulses++;
            if (pulses == 1) begin p1 = c; r1 = m8; end
            else begin p2 = c; r2 = m8; end
         end
         if (c == 5) mid_busy = busy8;
         if (c == 10) begin mid_m = m8; mid_rdy = rdy8; end
         if (c == 3) begin
            st8 = 1'b1; a8 = 8'd9; n8 = 8'd11;
         end else if (rdy8 && pulses == 1) begin
            st8 = 1'b1; a8 = 8'd9; n8 = 8'd13;
         end else begin
            st8 = 1'b0;
         end
      end
      check("busy_mid", 256'(mid_busy), 256'd1);
      check("busy_first_lat", 256'(p1), 256'd9);
      check("busy_first_m", 256'(r1), 256'd3);
      check("b2b_hold_m", 256'(mid_m), 256'd3);
      check("b2b_rdy_drop", 256'(mid_rdy), 256'd0);
      check("b2b_lat", 256'(p2), 256'd19);
      check("b2b_m", 256'(r2), 256'd1);
      check("pulse_count", 256'(pulses), 256'd2);

      // Boundary modulus 2^256 - 189 with a = N - 1
      nw = '1;
      nw = nw - 256'd188;
      run256(nw, nw - 256'd1, mw, lat);
      check("bnd_lat", 256'(lat), 256'd257);
      check("bnd_ref", to_mont(mw, nw), nw - 256'd1);
      check("bnd_lt_n", 256'(mw < nw), 256'd1);

      for (int v = 0; v < 200; v++) begin
         nw = rand256() | {1'b1, 254'd0, 1'b1};
         xw = rand256() % nw;
         aw = to_mont(xw, nw);
         run256(nw, aw, mw, lat);
         check("rand_m", mw, xw);
         if (v < 4) check("rand_lat", 256'(lat), 256'd257);
      end

      // Reset at iteration 100 of a 256-bit run
      nw = rand256() | {1'b1, 254'd0, 1'b1};
      xw = rand256() % nw;
      @(posedge clk); #1;
      n256 = nw; a256 = to_mont(xw, nw); st256 = 1'b1;
      @(posedge clk); #1;
      st256 = 1'b0;
      repeat (100) @(posedge clk);
      #3 rst = 1'b0;
      #1;
      check("arst_m256", m256, 256'd0);
      check("arst_busy256", 256'(busy256), 256'd0);
      check("arst_rdy256", 256'(rdy256), 256'd0);
      @(posedge clk); #2 rst = 1'b1;
      pulses = 0;
      for (int c = 0; c < 300; c++) begin
         @(posedge clk); #1;
         if (rdy256) pulses++;
      end
      check("arst_no_pulse", 256'(pulses), 256'd0);
      run256(nw, to_mont(xw, nw), mw, lat);
      check("post_rst_m", mw, xw);
      check("post_rst_lat", 256'(lat), 256'd257);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
